// File: rtl/cla_pkg.sv
// Shared types and sizing for the 8-bit carry-lookahead datapath.
// Two 4-bit lookahead groups make up one word.
package cla_pkg;
    localparam int CLA_W = 8;
    localparam int GRP_W = 4;
    localparam int NGRP  = CLA_W / GRP_W;

    typedef logic [CLA_W-1:0] cla_word_t;

    typedef struct packed {
        cla_word_t       p;
        cla_word_t       g;
        logic [NGRP-1:0] grp_p;
        logic [NGRP-1:0] grp_g;
        logic            cin;
        logic            a_msb;
        logic            b_msb;
    } s1_regs_t;
endpackage

// File: rtl/cla4_group.sv
// One 4-bit lookahead group: group propagate/generate plus the carry into
// each of its four bit positions.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] p,
    input  logic [GRP_W-1:0] g,
    input  logic             cin,
    output logic             grp_p,
    output logic             grp_g,
    output logic [GRP_W-1:0] c
);
    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

    // c[i] is the carry into bit i, flattened so no ripple path exists.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
endmodule

// File: rtl/addsub8_pipe.sv
// Two-stage pipelined 8-bit CLA adder/subtractor with valid/ready flow control.
// S1 registers bit and group propagate/generate; S2 resolves carries and flags.
module addsub8_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    logic            s1_valid_reg;
    logic            s2_valid_reg;
    s1_regs_t        s1_reg;
    s1_regs_t        s1_next;
    cla_word_t       sum_reg;
    logic            cout_reg;
    logic            ovf_reg;
    logic            zero_reg;

    logic            s1_adv;
    logic            s2_adv;
    logic            in_fire;

    cla_word_t       b_x;
    cla_word_t       p_comb;
    cla_word_t       g_comb;
    logic [NGRP-1:0] s1_grp_p;
    logic [NGRP-1:0] s1_grp_g;
    logic [GRP_W-1:0] s1_carry_unused [NGRP];

    logic            c4;
    logic            c8;
    logic [NGRP-1:0] grp_cin;
    cla_word_t       carry_vec;
    logic [NGRP-1:0] s2_grp_p_unused;
    logic [NGRP-1:0] s2_grp_g_unused;
    cla_word_t       sum_next;
    logic            ovf_next;
    logic            zero_next;

    assign s2_adv   = ~s2_valid_reg | out_ready;
    assign s1_adv   = ~s1_valid_reg | s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid & s1_adv;

    // Subtraction is A + ~B + 1: invert B here and feed the +1 as cin.
    assign b_x    = b ^ {CLA_W{sub}};
    assign p_comb = a ^ b_x;
    assign g_comb = a & b_x;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1_grp
            cla4_group u_grp (
                .p     (p_comb[gi*GRP_W +: GRP_W]),
                .g     (g_comb[gi*GRP_W +: GRP_W]),
                .cin   (1'b0),
                .grp_p (s1_grp_p[gi]),
                .grp_g (s1_grp_g[gi]),
                .c     (s1_carry_unused[gi])
            );
        end
    endgenerate

    always_comb begin
        s1_next       = '0;
        s1_next.p     = p_comb;
        s1_next.g     = g_comb;
        s1_next.grp_p = s1_grp_p;
        s1_next.grp_g = s1_grp_g;
        s1_next.cin   = sub;
        s1_next.a_msb = a[CLA_W-1];
        s1_next.b_msb = b_x[CLA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else begin
            if (s1_adv)
                s1_valid_reg <= in_valid;
            if (in_fire)
                s1_reg <= s1_next;
        end
    end

    assign c4      = s1_reg.grp_g[0] | (s1_reg.grp_p[0] & s1_reg.cin);
    assign c8      = s1_reg.grp_g[1] | (s1_reg.grp_p[1] & c4);
    assign grp_cin = {c4, s1_reg.cin};

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2_grp
            cla4_group u_grp (
                .p     (s1_reg.p[gi*GRP_W +: GRP_W]),
                .g     (s1_reg.g[gi*GRP_W +: GRP_W]),
                .cin   (grp_cin[gi]),
                .grp_p (s2_grp_p_unused[gi]),
                .grp_g (s2_grp_g_unused[gi]),
                .c     (carry_vec[gi*GRP_W +: GRP_W])
            );
        end
    endgenerate

    assign sum_next  = s1_reg.p ^ carry_vec;
    assign ovf_next  = (s1_reg.a_msb == s1_reg.b_msb) & (sum_next[CLA_W-1] != s1_reg.a_msb);
    assign zero_next = (sum_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            if (s2_adv)
                s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg && s2_adv) begin
                sum_reg  <= sum_next;
                cout_reg <= c8;
                ovf_reg  <= ovf_next;
                zero_reg <= zero_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;
endmodule

// File: tb/tb_addsub8_pipe.sv
// Scoreboard bench for addsub8_pipe: arithmetic reference model, decoupled
// input capture / output monitor, directed, random, backpressure and reset cases.
module tb_addsub8_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         acc_edge;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    addsub8_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed result for ovf.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic s, input int edge_no);
        exp_t r;
        int ux = int'(x);
        int uy = int'(y);
        int sx = (ux > 127) ? ux - 256 : ux;
        int sy = (uy > 127) ? uy - 256 : uy;
        int ures = s ? ux - uy : ux + uy;
        int sres = s ? sx - sy : sx + sy;
        r.sum      = 8'(ures & 255);
        r.cout     = s ? (ux >= uy) : (ures > 255);
        r.ovf      = (sres < -128) || (sres > 127);
        r.zero     = ((ures & 255) == 0);
        r.acc_edge = edge_no;
        return r;
    endfunction

    logic       prev_hold = 1'b0;
    logic [7:0] prev_sum;
    logic [2:0] prev_flags;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_sum", int'(sum), int'(prev_sum));
                chk("hold_flags", int'({cout, ovf, zero}), int'(prev_flags));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual sum=0x%0h required=no result t=%0t", sum, $time);
                end else begin
                    e = sb.pop_front();
                    chk("sum", int'(sum), int'(e.sum));
                    chk("cout", int'(cout), int'(e.cout));
                    chk("ovf", int'(ovf), int'(e.ovf));
                    chk("zero", int'(zero), int'(e.zero));
                    if (lat_chk)
                        chk("latency", cyc + 1 - e.acc_edge, 2);
                    $display("result edge=%0d sum=0x%02h cout=%0b ovf=%0b zero=%0b (exp 0x%02h %0b %0b %0b)",
                             cyc + 1, sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_sum   = sum;
            prev_flags = {cout, ovf, zero};
            if (in_valid && in_ready)
                sb.push_back(model(a, b, sub, cyc + 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] x, input logic [7:0] y, input logic s);
        int n = 0;
        bit acc = 1'b0;
        a = x;
        b = y;
        sub = s;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout actual=not accepted required=accepted within 50 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required=0", sb.size());
        end
    endtask

    logic [7:0] dir_a [5] = '{8'h7F, 8'h05, 8'h00, 8'hFF, 8'h80};
    logic [7:0] dir_b [5] = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h80};
    logic       dir_s [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int idx;
        int stall;
        bit seen;
        bit acc;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_sum", int'(sum), 0);
        chk("rst_flags", int'({cout, ovf, zero}), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        tick();

        // Directed corner cases, pipeline idle between each.
        for (int i = 0; i < 5; i++) begin
            send1(dir_a[i], dir_b[i], dir_s[i]);
            drain();
        end

        // Back-to-back random stream at full rate.
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            chk("tp_in_ready", int'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: consumer stalls 3 cycles once the first result shows.
        lat_chk = 1'b0;
        idx = 0;
        stall = 0;
        seen = 1'b0;
        for (int n = 0; n < 60 && (idx < 4 || sb.size() != 0); n++) begin
            if (idx < 4) begin
                in_valid = 1'b1;
                a = 8'(8'h30 + idx * 8'h21);
                b = 8'(8'h11 * (idx + 1));
                sub = 1'(idx);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc)
                idx++;
            if (!seen && out_valid) begin
                seen = 1'b1;
                out_ready = 1'b0;
                stall = 3;
                chk("bp_accepts_before_stall", idx, 2);
            end else if (stall > 0) begin
                chk("bp_in_ready_low", int'(in_ready), 0);
                stall--;
                if (stall == 0)
                    out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_accepted", idx, 4);
        drain();

        // Random valid/ready on both sides.
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            sub = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with both stages full: everything in flight is discarded.
        out_ready = 1'b0;
        send1(8'h11, 8'h22, 1'b0);
        send1(8'h33, 8'h44, 1'b1);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_sum", int'(sum), 0);
        chk("mid_rst_flags", int'({cout, ovf, zero}), 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        repeat (5) tick();
        chk("post_rst_idle", int'(out_valid), 0);
        send1(8'h12, 8'h34, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
